// File: rtl/flash_read_responder_pkg.sv
// flash_resp_pkg: shared widths, types and the address-derived sample pattern
// used by flash_read_responder and by anything that needs to predict its data.
//   FLASH_ADDR_W : word address width of the flash read port
//   FLASH_DATA_W : data width of the flash read port
//   sample_word  : pattern for an in-range address (range check is the caller's job)
package flash_resp_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int FLASH_DATA_W = 32;

    typedef logic [FLASH_ADDR_W-1:0] flash_addr_t;
    typedef logic [FLASH_DATA_W-1:0] flash_data_t;

    // Low half is {A[14:0],0}, high half is {A[14:0],1}: two distinct
    // 16-bit samples per word, so byte/half swaps show up immediately.
    function automatic flash_data_t sample_word(input flash_addr_t addr);
        return {addr[14:0], 1'b1, addr[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/flash_read_responder_if.sv
// flash_read_responder_if: Avalon-MM read-only port between the audio player
// (master) and its flash memory (slave).
//   read          : read request                      (master -> slave)
//   address       : word address                      (master -> slave)
//   waitrequest   : request not accepted this cycle   (slave -> master)
//   readdatavalid : readdata valid this cycle         (slave -> master)
//   readdata      : returned word                     (slave -> master)
interface flash_read_responder_if;
    import flash_resp_pkg::*;

    logic        read;
    flash_addr_t address;
    logic        waitrequest;
    logic        readdatavalid;
    flash_data_t readdata;

    modport master (
        output read,
        output address,
        input  waitrequest,
        input  readdatavalid,
        input  readdata
    );

    modport slave (
        input  read,
        input  address,
        output waitrequest,
        output readdatavalid,
        output readdata
    );

endinterface

// File: rtl/flash_read_responder_delay_line.sv
// flash_delay_line: fixed-latency pipe of {valid, data} stages.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low clear of all stages
//   in_valid  : loads stage 0 valid
//   in_data   : loaded into stage 0 when in_valid
//   out_valid : last stage valid
//   out_data  : last stage data; holds the last valid word between pulses
module flash_delay_line #(
    parameter int LATENCY = 3,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // Data only moves together with a valid token, so every stage (and in
    // particular the output stage) keeps the last word that passed through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/flash_read_responder.sv
// flash_read_responder: read-only stand-in for the on-board flash controller.
// Answers every accepted read with an address-derived word after a fixed
// latency, limits outstanding reads and can insert periodic one-cycle stalls.
//   CLK_50M      : clock, rising edge
//   RESET_N      : asynchronous active-low reset
//   flash_mem    : Avalon-MM read port (slave side)
//   out_of_range : sticky; a read above ADDR_MAX has been accepted
module flash_read_responder
    import flash_resp_pkg::*;
#(
    parameter int          LATENCY     = 3,
    parameter int          MAX_PENDING = 4,
    parameter int          WAIT_EVERY  = 0,
    parameter flash_addr_t ADDR_MAX    = 23'h7FFFF
) (
    input  logic                   CLK_50M,
    input  logic                   RESET_N,
    flash_read_responder_if.slave  flash_mem,
    output logic                   out_of_range
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);

    logic [PEND_W-1:0] pending;
    logic              stall;
    logic              accept;
    logic              retire;
    logic              addr_bad;
    flash_data_t       resp_word;

    // Built from registers (and reset) only, so the requester can never form
    // a combinational loop through read -> waitrequest.
    assign flash_mem.waitrequest = ~RESET_N | stall | (pending == PEND_FULL);

    assign accept    = flash_mem.read & ~flash_mem.waitrequest;
    assign retire    = flash_mem.readdatavalid;
    assign addr_bad  = flash_mem.address > ADDR_MAX;
    assign resp_word = addr_bad ? '0 : sample_word(flash_mem.address);

    flash_delay_line #(
        .LATENCY (LATENCY),
        .WIDTH   (FLASH_DATA_W)
    ) u_delay (
        .clk       (CLK_50M),
        .rst_n     (RESET_N),
        .in_valid  (accept),
        .in_data   (resp_word),
        .out_valid (flash_mem.readdatavalid),
        .out_data  (flash_mem.readdata)
    );

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            pending <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            out_of_range <= 1'b0;
        end else if (accept && addr_bad) begin
            out_of_range <= 1'b1;
        end
    end

    generate
        if (WAIT_EVERY > 0) begin : g_stall
            localparam int ACC_W = (WAIT_EVERY > 1) ? $clog2(WAIT_EVERY) : 1;
            localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(WAIT_EVERY - 1);

            logic [ACC_W-1:0] acc_cnt;

            // stall lasts exactly one cycle; waitrequest blocks accepts
            // during it, so acc_cnt cannot move while it is high.
            always_ff @(posedge CLK_50M or negedge RESET_N) begin
                if (!RESET_N) begin
                    acc_cnt <= '0;
                    stall   <= 1'b0;
                end else begin
                    stall <= 1'b0;
                    if (accept) begin
                        if (acc_cnt == ACC_LAST) begin
                            acc_cnt <= '0;
                            stall   <= 1'b1;
                        end else begin
                            acc_cnt <= acc_cnt + ACC_W'(1);
                        end
                    end
                end
            end
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

endmodule
